// File: rtl/track_counter_pkg.sv
// Shared types and next-count arithmetic for the multi-channel step counters.
// Pure definitions: no latency, no flow control.
package track_counter_pkg;

    localparam int CNT_MAX_W = 64;

    typedef enum logic {
        LOAD_IDLE = 1'b0,
        LOAD_COOL = 1'b1
    } load_state_t;

    // Counter widths up to CNT_MAX_W-1 are carried zero-extended; bits at and above
    // `width` in the result are always zero.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] cur,
        input logic [CNT_MAX_W-1:0] step,
        input int                   width,
        input logic                 saturate
    );
        logic [CNT_MAX_W:0]   sum;
        logic [CNT_MAX_W-1:0] ones;
        ones = (CNT_MAX_W'(1) << width) - CNT_MAX_W'(1);
        sum  = {1'b0, cur} + {1'b0, step};
        if (sum > {1'b0, ones}) begin
            return saturate ? ones : (sum[CNT_MAX_W-1:0] & ones);
        end
        return sum[CNT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/track_counter_channel.sv
// One channel: step counter, combinational scaled copy, filtered held register.
// Latency: 1 cycle for count/held/wrap/sat, 0 for scaled; no backpressure (load is pre-arbitrated).
module track_counter_channel
    import track_counter_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int unsigned STEP        = 1,
    parameter int          SHIFT       = 1,
    parameter int          FILTER_BITS = 1,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] scaled,
    output logic [WIDTH-1:0] held,
    output logic             held_valid,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0]     count_q;
    logic [WIDTH-1:0]     held_q;
    logic                 held_vld_q;
    logic                 wrap_q;
    logic                 sat_q;
    logic                 ovf;
    logic [CNT_MAX_W-1:0] nxt_wide;
    logic [WIDTH-1:0]     nxt;
    logic                 unused_nxt_hi;

    assign ovf           = ({1'b0, count_q} + STEP_EXT) > {1'b0, {WIDTH{1'b1}}};
    assign nxt_wide      = next_count(CNT_MAX_W'(count_q), CNT_MAX_W'(STEP), WIDTH, SATURATE);
    assign nxt           = nxt_wide[WIDTH-1:0];
    assign unused_nxt_hi = ^nxt_wide[CNT_MAX_W-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else if (clr) begin
            count_q    <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            // Capture looks at the pre-edge count, so a same-edge load is not seen.
            if (count_q[FILTER_BITS-1:0] == '0) begin
                held_q     <= count_q;
                held_vld_q <= 1'b1;
            end
            wrap_q <= 1'b0;
            if (load) begin
                // A loaded value is no longer pinned at all-ones, so the flag drops.
                count_q <= load_data;
                sat_q   <= 1'b0;
            end else if (en) begin
                count_q <= nxt;
                if (ovf && !sat_q) wrap_q <= 1'b1;
                if (ovf && SATURATE) sat_q <= 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign scaled     = count_q << SHIFT;
    assign held       = held_q;
    assign held_valid = held_vld_q;
    assign wrap       = wrap_q;
    assign sat        = sat_q;

endmodule

// File: rtl/multi_track_counter.sv
// Array of independent step counters sharing one load port with a one-cycle cooldown.
// Latency: 1 cycle for all registered outputs; load_ready drops for one cycle after each accept.
module multi_track_counter
    import track_counter_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          CHANNELS    = 4,
    parameter int unsigned STEP        = 1,
    parameter int          SHIFT       = 1,
    parameter int          FILTER_BITS = 1,
    parameter bit          SATURATE    = 1'b0,
    localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [CH_W-1:0]           load_ch,
    input  logic [WIDTH-1:0]          load_data,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS*WIDTH-1:0] scaled,
    output logic [CHANNELS*WIDTH-1:0] held,
    output logic [CHANNELS-1:0]       held_valid,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       sat
);

    load_state_t state_q;
    load_state_t state_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= LOAD_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        accept     = 1'b0;
        case (state_q)
            LOAD_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD_COOL;
                end
            end
            LOAD_COOL: state_d = LOAD_IDLE;
            default:   state_d = LOAD_IDLE;
        endcase
    end

    // Out-of-range load_ch matches no channel: the request is consumed and dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic load_hit;
        assign load_hit = accept && (load_ch == CH_W'(i));

        track_counter_channel #(
            .WIDTH      (WIDTH),
            .STEP       (STEP),
            .SHIFT      (SHIFT),
            .FILTER_BITS(FILTER_BITS),
            .SATURATE   (SATURATE)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en[i]),
            .clr       (clr[i]),
            .load      (load_hit),
            .load_data (load_data),
            .count     (count[i*WIDTH +: WIDTH]),
            .scaled    (scaled[i*WIDTH +: WIDTH]),
            .held      (held[i*WIDTH +: WIDTH]),
            .held_valid(held_valid[i]),
            .wrap      (wrap[i]),
            .sat       (sat[i])
        );
    end

endmodule

// File: tb/tb_multi_track_counter.sv
// Two instances (wrapping and saturating) on shared stimulus, checked against hand tables and a model.
module tb_multi_track_counter;

    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int MAXV = 255;
    localparam int STEP = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [CH-1:0] en, clr;
    logic          load_valid;
    logic [1:0]    load_ch;
    logic [W-1:0]  load_data;

    logic            ready_w, ready_s;
    logic [CH*W-1:0] count_w, scaled_w, held_w, count_s, scaled_s, held_s;
    logic [CH-1:0]   hv_w, wrap_w, sat_w, hv_s, wrap_s, sat_s;

    multi_track_counter #(.WIDTH(W), .CHANNELS(CH), .STEP(STEP), .SHIFT(1),
                          .FILTER_BITS(1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .load_valid(load_valid), .load_ready(ready_w), .load_ch(load_ch), .load_data(load_data),
        .count(count_w), .scaled(scaled_w), .held(held_w), .held_valid(hv_w),
        .wrap(wrap_w), .sat(sat_w));

    multi_track_counter #(.WIDTH(W), .CHANNELS(CH), .STEP(STEP), .SHIFT(1),
                          .FILTER_BITS(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .load_valid(load_valid), .load_ready(ready_s), .load_ch(load_ch), .load_data(load_data),
        .count(count_s), .scaled(scaled_s), .held(held_s), .held_valid(hv_s),
        .wrap(wrap_s), .sat(sat_s));

    int checks   = 0;
    int failures = 0;

    // Reference state: index 0 = wrapping instance, 1 = saturating instance.
    int m_count [2][CH];
    int m_held  [2][CH];
    bit m_hv    [2][CH];
    bit m_wrap  [2][CH];
    bit m_sat   [2][CH];
    bit m_ready;

    task automatic chk(input string name, input int d, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d ch%0d: got %0d expected %0d @%0t", name, d, c, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        int s;
        acc = m_ready && load_valid;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (!rst_n || clr[c]) begin
                    m_count[d][c] = 0; m_held[d][c] = 0; m_hv[d][c] = 0;
                    m_wrap[d][c]  = 0; m_sat[d][c]  = 0;
                end else begin
                    if (m_count[d][c] % 2 == 0) begin
                        m_held[d][c] = m_count[d][c];
                        m_hv[d][c]   = 1;
                    end
                    m_wrap[d][c] = 0;
                    if (acc && int'(load_ch) == c) begin
                        m_count[d][c] = int'(load_data);
                        m_sat[d][c]   = 0;
                    end else if (en[c]) begin
                        s = m_count[d][c] + STEP;
                        if (s > MAXV) begin
                            if (d == 1) begin
                                m_wrap[d][c]  = !m_sat[d][c];
                                m_count[d][c] = MAXV;
                                m_sat[d][c]   = 1;
                            end else begin
                                m_wrap[d][c]  = 1;
                                m_count[d][c] = s - (MAXV + 1);
                            end
                        end else begin
                            m_count[d][c] = s;
                        end
                    end
                end
            end
        end
        m_ready = rst_n ? !acc : 1'b1;
    endtask

    task automatic check_all();
        logic [CH*W-1:0] cnt, scl, hld;
        logic [CH-1:0]   hv, wr, st;
        logic            rdy;
        for (int d = 0; d < 2; d++) begin
            cnt = (d == 0) ? count_w  : count_s;
            scl = (d == 0) ? scaled_w : scaled_s;
            hld = (d == 0) ? held_w   : held_s;
            hv  = (d == 0) ? hv_w     : hv_s;
            wr  = (d == 0) ? wrap_w   : wrap_s;
            st  = (d == 0) ? sat_w    : sat_s;
            rdy = (d == 0) ? ready_w  : ready_s;
            chk("load_ready", d, 0, int'(rdy), int'(m_ready));
            for (int c = 0; c < CH; c++) begin
                chk("count",      d, c, int'(cnt[c*W +: W]), m_count[d][c]);
                chk("scaled",     d, c, int'(scl[c*W +: W]), (m_count[d][c] * 2) % (MAXV + 1));
                chk("held",       d, c, int'(hld[c*W +: W]), m_held[d][c]);
                chk("held_valid", d, c, int'(hv[c]),  int'(m_hv[d][c]));
                chk("wrap",       d, c, int'(wr[c]),  int'(m_wrap[d][c]));
                chk("sat",        d, c, int'(st[c]),  int'(m_sat[d][c]));
            end
        end
    endtask

    task automatic step(input logic r, input logic [CH-1:0] e, input logic [CH-1:0] cl,
                        input logic lv, input logic [1:0] lc, input logic [W-1:0] ld);
        rst_n = r; en = e; clr = cl; load_valid = lv; load_ch = lc; load_data = ld;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic          rst_n;
        logic [CH-1:0] en;
        logic [CH-1:0] clr;
        logic          lv;
        logic [1:0]    lch;
        logic [W-1:0]  ld;
        int            ch;
        logic [W-1:0]  exp_cnt_w;
        logic [W-1:0]  exp_cnt_s;
        logic          exp_wrap_w;
        logic          exp_wrap_s;
        logic          exp_sat_s;
        logic          exp_hv;
        logic          exp_ready;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic          r, lv;
        logic [CH-1:0] e, cl;
        logic [1:0]    lc;
        logic [W-1:0]  ld;

        //           rst en    clr   lv lch   ld     ch cnt_w  cnt_s  ww ws ss hv rdy
        vt[0]  = '{1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 8'hFE, 1, 8'hFE, 8'hFE, 0, 0, 0, 1, 0};
        vt[1]  = '{1'b1, 4'h2, 4'h0, 1'b0, 2'd0, 8'h00, 1, 8'hFF, 8'hFF, 0, 0, 0, 1, 1};
        vt[2]  = '{1'b1, 4'h2, 4'h0, 1'b0, 2'd0, 8'h00, 1, 8'h00, 8'hFF, 1, 1, 1, 1, 1};
        vt[3]  = '{1'b1, 4'h2, 4'h0, 1'b0, 2'd0, 8'h00, 1, 8'h01, 8'hFF, 0, 0, 1, 1, 1};
        vt[4]  = '{1'b1, 4'h2, 4'h0, 1'b0, 2'd0, 8'h00, 1, 8'h02, 8'hFF, 0, 0, 1, 1, 1};
        vt[5]  = '{1'b1, 4'h2, 4'h2, 1'b0, 2'd0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0, 0, 1};
        vt[6]  = '{1'b1, 4'h0, 4'h0, 1'b1, 2'd2, 8'h05, 2, 8'h05, 8'h05, 0, 0, 0, 1, 0};
        vt[7]  = '{1'b1, 4'h0, 4'h0, 1'b1, 2'd2, 8'h09, 2, 8'h05, 8'h05, 0, 0, 0, 1, 1};
        vt[8]  = '{1'b1, 4'h0, 4'h0, 1'b1, 2'd2, 8'h09, 2, 8'h09, 8'h09, 0, 0, 0, 1, 0};
        vt[9]  = '{1'b1, 4'h8, 4'h0, 1'b0, 2'd0, 8'h00, 3, 8'h01, 8'h01, 0, 0, 0, 1, 1};
        vt[10] = '{1'b1, 4'h0, 4'h8, 1'b1, 2'd3, 8'h07, 3, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        vt[11] = '{1'b1, 4'h8, 4'h0, 1'b0, 2'd0, 8'h00, 3, 8'h01, 8'h01, 0, 0, 0, 1, 1};
        vt[12] = '{1'b1, 4'hF, 4'h0, 1'b1, 2'd0, 8'h33, 0, 8'h33, 8'h33, 0, 0, 0, 1, 0};
        vt[13] = '{1'b0, 4'hF, 4'h0, 1'b1, 2'd0, 8'h44, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1};
        vt[14] = '{1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 0, 8'h01, 8'h01, 0, 0, 0, 1, 1};

        rst_n = 1'b0; en = '0; clr = '0; load_valid = 1'b0; load_ch = '0; load_data = '0;
        m_ready = 1'b1;
        @(negedge clk);
        step(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
        chk("rst_ready",  0, 0, int'(ready_w),        1);
        chk("rst_count",  0, 0, int'(count_w[7:0]),   0);
        chk("rst_hv",     1, 0, int'(hv_s[0]),        0);

        // Free-running count on ch0: held trails by one edge and only takes even values.
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 4'h1, 4'h0, 1'b0, 2'd0, 8'h00);
            chk("t1_count",  0, 0, int'(count_w[7:0]),  k);
            chk("t1_scaled", 0, 0, int'(scaled_w[7:0]), 2 * k);
            chk("t1_held",   0, 0, int'(held_w[7:0]),   ((k - 1) / 2) * 2);
            chk("t1_hv",     0, 0, int'(hv_w[0]),       1);
        end

        for (int i = 0; i < 15; i++) begin
            step(vt[i].rst_n, vt[i].en, vt[i].clr, vt[i].lv, vt[i].lch, vt[i].ld);
            chk($sformatf("vec%0d_count", i),  0, vt[i].ch, int'(count_w[vt[i].ch*W +: W]), int'(vt[i].exp_cnt_w));
            chk($sformatf("vec%0d_count", i),  1, vt[i].ch, int'(count_s[vt[i].ch*W +: W]), int'(vt[i].exp_cnt_s));
            chk($sformatf("vec%0d_wrap", i),   0, vt[i].ch, int'(wrap_w[vt[i].ch]),  int'(vt[i].exp_wrap_w));
            chk($sformatf("vec%0d_wrap", i),   1, vt[i].ch, int'(wrap_s[vt[i].ch]),  int'(vt[i].exp_wrap_s));
            chk($sformatf("vec%0d_sat", i),    1, vt[i].ch, int'(sat_s[vt[i].ch]),   int'(vt[i].exp_sat_s));
            chk($sformatf("vec%0d_hv", i),     0, vt[i].ch, int'(hv_w[vt[i].ch]),    int'(vt[i].exp_hv));
            chk($sformatf("vec%0d_ready", i),  0, vt[i].ch, int'(ready_w),           int'(vt[i].exp_ready));
        end

        // Randomised traffic, loads biased toward the top of the range to provoke overflow.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 63) != 0);
            e  = CH'($urandom);
            cl = '0;
            for (int c = 0; c < CH; c++) cl[c] = ($urandom_range(0, 15) == 0);
            lv = 1'($urandom_range(0, 1));
            lc = 2'($urandom);
            ld = ($urandom_range(0, 1) != 0) ? (8'hF8 | 8'($urandom_range(0, 7))) : 8'($urandom);
            step(r, e, cl, lv, lc, ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
